// File: rtl/exhaustive_stim_sequencer.sv
// Exhaustive stimulus sequencer: sweeps every WIDTH-bit vector with a start/done handshake
// and counts sampled responses with bit 0 high. Optional MISR signature under STIM_SIG_EN.
module exhaustive_stim_sequencer #(
   parameter int WIDTH  = 3,
   parameter int HOLD   = 10,
   parameter int RESP_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [RESP_W-1:0] resp_in,
   output logic [WIDTH-1:0]  vec_out,
   output logic              vec_valid,
   output logic              busy,
   output logic              done,
   output logic [WIDTH:0]    ones_cnt,
   output logic [15:0]       sig_out
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [WIDTH-1:0] VEC_LAST  = {WIDTH{1'b1}};
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [WIDTH-1:0] vec_r, vec_s;
   logic [HW-1:0]    hold_r, hold_s;
   logic [WIDTH:0]   ones_r, ones_s;
   logic             vec_valid_r, busy_r, done_r;
   logic             start_acc_s, sample_s;

   // Next-state, counter and sample-strobe decode
   always_comb begin
      state_s     = state_r;
      vec_s       = vec_r;
      hold_s      = hold_r;
      ones_s      = ones_r;
      start_acc_s = 1'b0;
      sample_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s     = DRIVE;
               vec_s       = {WIDTH{1'b0}};
               hold_s      = {HW{1'b0}};
               ones_s      = {(WIDTH+1){1'b0}};
               start_acc_s = 1'b1;
            end else begin
               vec_s       = {WIDTH{1'b0}};
            end
         end
         DRIVE: begin
            // abort beats the final sample edge, so that sample is never counted
            if (abort) begin
               state_s = IDLE;
               vec_s   = {WIDTH{1'b0}};
               hold_s  = {HW{1'b0}};
            end else if (hold_r == HOLD_LAST) begin
               sample_s = 1'b1;
               ones_s   = ones_r + {{WIDTH{1'b0}}, resp_in[0]};
               hold_s   = {HW{1'b0}};
               if (vec_r == VEC_LAST) begin
                  state_s = DONE;
               end else begin
                  vec_s   = vec_r + WIDTH'(1);
               end
            end else begin
               hold_s = hold_r + HW'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
            vec_s   = {WIDTH{1'b0}};
            hold_s  = {HW{1'b0}};
         end
         default: begin
            state_s = IDLE;
            vec_s   = {WIDTH{1'b0}};
            hold_s  = {HW{1'b0}};
         end
      endcase
   end

   // State and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         vec_r       <= {WIDTH{1'b0}};
         hold_r      <= {HW{1'b0}};
         ones_r      <= {(WIDTH+1){1'b0}};
         vec_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         vec_r       <= vec_s;
         hold_r      <= hold_s;
         ones_r      <= ones_s;
         vec_valid_r <= (state_s == DRIVE);
         busy_r      <= (state_s != IDLE);
         done_r      <= (state_s == DONE);
      end
   end

   assign vec_out   = vec_r;
   assign vec_valid = vec_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign ones_cnt  = ones_r;

`ifdef STIM_SIG_EN
   logic [15:0] sig_r;

   function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                             input logic [RESP_W-1:0] resp);
      return {sig[14:0], sig[15] ^ sig[11] ^ sig[4]} ^ 16'(resp);
   endfunction

   // Response signature: seeded on start, folded once per sample edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_r <= 16'h0000;
      end else if (start_acc_s) begin
         sig_r <= 16'hFFFF;
      end else if (sample_s) begin
         sig_r <= misr_next(sig_r, resp_in);
      end else begin
         sig_r <= sig_r;
      end
   end

   assign sig_out = sig_r;
`else
   assign sig_out = 16'h0000;
`endif

endmodule

// File: tb/tb_exhaustive_stim_sequencer.sv
// Directed bench for exhaustive_stim_sequencer: a WIDTH=3/HOLD=10 instance for sweeps,
// abort and reset, plus a WIDTH=2/HOLD=1 instance for back-to-back starts.
module tb_exhaustive_stim_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, abort_a, resp_a;
   logic [2:0]  vec_a;
   logic        valid_a, busy_a, done_a;
   logic [3:0]  ones_a;
   logic [15:0] sig_a;
   logic        start_b, abort_b, resp_b;
   logic [1:0]  vec_b;
   logic        valid_b, busy_b, done_b;
   logic [2:0]  ones_b;
   logic [15:0] sig_b;
   int          resp_mode;
   int          n_cmp = 0;
   int          n_err = 0;

   exhaustive_stim_sequencer #(.WIDTH(3), .HOLD(10), .RESP_W(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .resp_in(resp_a),
      .vec_out(vec_a), .vec_valid(valid_a), .busy(busy_a), .done(done_a),
      .ones_cnt(ones_a), .sig_out(sig_a));

   exhaustive_stim_sequencer #(.WIDTH(2), .HOLD(1), .RESP_W(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .resp_in(resp_b),
      .vec_out(vec_b), .vec_valid(valid_b), .busy(busy_b), .done(done_b),
      .ones_cnt(ones_b), .sig_out(sig_b));

   always #5 clk = ~clk;

   always_comb begin
      if (resp_mode == 0) resp_a = ^vec_a;
      else                resp_a = (resp_mode == 1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic resp_of(input int mode, input int v);
      logic [2:0] vv;
      vv = 3'(v);
      if (mode == 0) return ^vv;
      else           return (mode == 1);
   endfunction

   function automatic logic [15:0] misr_model(input logic [15:0] s, input logic r);
      return {s[14:0], s[15] ^ s[11] ^ s[4]} ^ {15'd0, r};
   endfunction

   task automatic check_idle_a(input string tag);
      check_eq({tag, "_vec"},   32'(vec_a),   32'd0);
      check_eq({tag, "_valid"}, 32'(valid_a), 32'd0);
      check_eq({tag, "_busy"},  32'(busy_a),  32'd0);
      check_eq({tag, "_done"},  32'(done_a),  32'd0);
   endtask

   task automatic sweep_a(input int mode, input int exp_ones);
      logic [15:0] m;
      int bad;
      resp_mode = mode;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check_eq("start_valid", 32'(valid_a), 32'd1);
      check_eq("start_busy",  32'(busy_a),  32'd1);
      check_eq("start_ones",  32'(ones_a),  32'd0);
      bad = 0;
      for (int c = 0; c < 80; c++) begin
         if (c % 10 == 0) check_eq("sweep_vec", 32'(vec_a), 32'(c / 10));
         if (vec_a !== 3'(c / 10) || valid_a !== 1'b1 || done_a !== 1'b0) bad++;
         tick();
      end
      check_eq("hold_pattern", 32'(bad), 32'd0);
      check_eq("done_pulse",   32'(done_a),  32'd1);
      check_eq("done_vec",     32'(vec_a),   32'd7);
      check_eq("done_valid",   32'(valid_a), 32'd0);
      check_eq("done_busy",    32'(busy_a),  32'd1);
      check_eq("ones_cnt",     32'(ones_a),  32'(exp_ones));
      m = 16'hFFFF;
      for (int v = 0; v < 8; v++) m = misr_model(m, resp_of(mode, v));
`ifdef STIM_SIG_EN
      check_eq("sig", 32'(sig_a), 32'(m));
`else
      check_eq("sig_off", 32'(sig_a), 32'd0);
`endif
      tick();
      check_idle_a("after_done");
      check_eq("ones_hold", 32'(ones_a), 32'(exp_ones));
   endtask

   initial begin
      rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      resp_b = 1'b1; resp_mode = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check_idle_a("reset");
      check_eq("reset_ones", 32'(ones_a), 32'd0);
      check_eq("reset_sig",  32'(sig_a),  32'd0);

      // parity response, then constant responses
      sweep_a(0, 4);
      sweep_a(1, 8);
      sweep_a(2, 0);

      // abort while vec_out==3: partial count retained, no done
      resp_mode = 0;
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int c = 0; c < 30; c++) tick();
      check_eq("pre_abort_vec", 32'(vec_a), 32'd3);
      abort_a = 1'b1; tick(); abort_a = 1'b0;
      check_idle_a("abort");
      check_eq("abort_ones", 32'(ones_a), 32'd2);
      tick(); tick();
      check_eq("abort_no_done", 32'(done_a), 32'd0);
      sweep_a(0, 4);

      // abort on the final sample edge discards that sample
      resp_mode = 1;
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int c = 0; c < 79; c++) tick();
      abort_a = 1'b1; tick(); abort_a = 1'b0;
      check_idle_a("abort_last");
      check_eq("abort_last_ones", 32'(ones_a), 32'd7);

      // rst mid-sweep with start high
      resp_mode = 0;
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int c = 0; c < 50; c++) tick();
      check_eq("pre_rst_vec", 32'(vec_a), 32'd5);
      rst = 1'b1; start_a = 1'b1; tick();
      rst = 1'b0; start_a = 1'b0;
      check_idle_a("mid_rst");
      check_eq("mid_rst_ones", 32'(ones_a), 32'd0);
      check_eq("mid_rst_sig",  32'(sig_a),  32'd0);
      tick();
      check_eq("no_sweep_after_rst", 32'(valid_a), 32'd0);

      // start held high on the WIDTH=2, HOLD=1 instance
      start_b = 1'b1;
      for (int v = 0; v < 4; v++) begin
         tick();
         check_eq("b_vec",   32'(vec_b),   32'(v));
         check_eq("b_valid", 32'(valid_b), 32'd1);
      end
      tick();
      check_eq("b_done",     32'(done_b), 32'd1);
      check_eq("b_done_vec", 32'(vec_b),  32'd3);
      check_eq("b_ones",     32'(ones_b), 32'd4);
      tick();
      check_eq("b_idle_valid", 32'(valid_b), 32'd0);
      check_eq("b_idle_done",  32'(done_b),  32'd0);
      tick();
      check_eq("b_restart_valid", 32'(valid_b), 32'd1);
      check_eq("b_restart_vec",   32'(vec_b),   32'd0);
      start_b = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      check_eq("b_done2", 32'(done_b), 32'd1);
      tick();
      check_eq("b_idle2_busy", 32'(busy_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
